// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter
// ---------------------------------------------------------------------------
// Round-robin arbiter and sequencer in front of a shared 8:1 single-bit mux.
// One requester owns the mux at a time. Each grant lasts for a bounded burst.
// Between owners there is at least one idle cycle, so the mux select never
// changes while a grant is active.
//
// Parameters
//   BURST_MAX  maximum consecutive granted cycles per owner (0 = unlimited,
//              hold until the owner drops its request)
//   CNT_W      burst counter width; BURST_MAX must be below 2**CNT_W
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   req[7:0]   request per source; bit i corresponds to mux data input i
//   sl[2:0]    registered mux select; holds its value while idle
//   gnt[7:0]   registered one-hot grant; all-zero when idle
//   busy       high while a grant is active (|gnt)
//   burst_cnt  granted cycles so far in the current grant; 0 when idle
// ---------------------------------------------------------------------------
module mux8_rr_arbiter #(
  parameter int BURST_MAX = 4,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       req,
  output logic [2:0]       sl,
  output logic [7:0]       gnt,
  output logic             busy,
  output logic [CNT_W-1:0] burst_cnt
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

  logic [0:0] state;
  logic [2:0] ptr;

  logic       found;
  logic [2:0] winner;
  logic [2:0] idx;
  logic       release_now;

  // Rotating priority search: scan req starting at ptr, wrapping 7 -> 0.
  // The 3-bit add gives the wrap for free. Only the first hit is kept.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    idx    = ptr;
    for (int k = 0; k < 8; k++) begin
      idx = ptr + 3'(k);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // The owner lets go when it drops its request, or when a bounded burst
  // has used up its allowance. Other requesters never preempt.
  always_comb begin
    release_now = 1'b0;
    if (!req[sl]) begin
      release_now = 1'b1;
    end else if ((BURST_MAX != 0) && (burst_cnt == CNT_LIMIT)) begin
      release_now = 1'b1;
    end
  end

  // Sequencer. sl is only loaded on IDLE -> GRANT, so the mux input stays
  // put through release and idle. After a release, ptr moves to the slot
  // just past the old owner. That keeps every active requester from starving.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sl        <= 3'd0;
      gnt       <= 8'h00;
      burst_cnt <= '0;
      ptr       <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            state     <= ST_GRANT;
            sl        <= winner;
            gnt       <= 8'h01 << winner;
            burst_cnt <= CNT_W'(1);
          end
        end
        ST_GRANT: begin
          if (release_now) begin
            state     <= ST_IDLE;
            gnt       <= 8'h00;
            burst_cnt <= '0;
            ptr       <= sl + 3'd1;
          end else if (burst_cnt != CNT_SAT) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= ST_IDLE;
          gnt       <= 8'h00;
          burst_cnt <= '0;
        end
      endcase
    end
  end

  assign busy = |gnt;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter
// ---------------------------------------------------------------------------
// Bench for mux8_rr_arbiter. One instance uses the default bounded burst
// (BURST_MAX=4) and is driven from a table of per-cycle vectors. A second
// instance with BURST_MAX=0 is driven by a hand-written sequence that covers
// counter saturation and the no-preemption rule.
// ---------------------------------------------------------------------------
module tb_mux8_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] req_u = 8'h00;

  logic [2:0] sl,   sl_u;
  logic [7:0] gnt,  gnt_u;
  logic       busy, busy_u;
  logic [3:0] cnt,  cnt_u;

  int checks = 0;
  int errors = 0;

  mux8_rr_arbiter #(.BURST_MAX(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .sl(sl), .gnt(gnt), .busy(busy), .burst_cnt(cnt)
  );

  mux8_rr_arbiter #(.BURST_MAX(0), .CNT_W(4)) dut_u (
    .clk(clk), .rst(rst), .req(req_u),
    .sl(sl_u), .gnt(gnt_u), .busy(busy_u), .burst_cnt(cnt_u)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [2:0] sl;
    logic [7:0] gnt;
    logic [3:0] cnt;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic r, input logic [7:0] q, input logic [2:0] s,
                        input logic [7:0] g, input logic [3:0] c, input string n);
    vec_t v;
    v.rst = r; v.req = q; v.sl = s; v.gnt = g; v.cnt = c; v.name = n;
    vecs.push_back(v);
  endtask

  // Drive inputs, let one rising edge pass, then settle away from the edge.
  task automatic applyStimulus(input logic r, input logic [7:0] q, input logic [7:0] qu);
    rst   = r;
    req   = q;
    req_u = qu;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string n,
                             input logic [2:0] a_sl, input logic [7:0] a_gnt,
                             input logic a_busy, input logic [3:0] a_cnt,
                             input logic [2:0] e_sl, input logic [7:0] e_gnt,
                             input logic [3:0] e_cnt);
    logic e_busy;
    e_busy = (e_gnt != 8'h00);
    checks++;
    if (a_sl !== e_sl || a_gnt !== e_gnt || a_busy !== e_busy || a_cnt !== e_cnt) begin
      errors++;
      $display("[TB] FAIL %s: got sl=%0d gnt=%02h busy=%0b cnt=%0d, expected sl=%0d gnt=%02h busy=%0b cnt=%0d",
               n, a_sl, a_gnt, a_busy, a_cnt, e_sl, e_gnt, e_busy, e_cnt);
    end
  endtask

  initial begin
    // Reset with all requests high, then idle.
    addVec(1, 8'hFF, 0, 8'h00, 0, "rst0");
    addVec(1, 8'hFF, 0, 8'h00, 0, "rst1");
    addVec(0, 8'h00, 0, 8'h00, 0, "idle0");
    addVec(0, 8'h00, 0, 8'h00, 0, "idle1");
    // Single requester 3: four-cycle burst, turnaround, then a fresh grant.
    addVec(0, 8'h08, 3, 8'h08, 1, "single_c1");
    addVec(0, 8'h08, 3, 8'h08, 2, "single_c2");
    addVec(0, 8'h08, 3, 8'h08, 3, "single_c3");
    addVec(0, 8'h08, 3, 8'h08, 4, "single_c4");
    addVec(0, 8'h08, 3, 8'h00, 0, "single_turn");
    addVec(0, 8'h08, 3, 8'h08, 1, "single_regrant");
    addVec(0, 8'h00, 3, 8'h00, 0, "single_drop");
    addVec(1, 8'h00, 0, 8'h00, 0, "rst_before_rr");
    // Round-robin between 0 and 7.
    addVec(0, 8'h81, 0, 8'h01, 1, "rr0_c1");
    addVec(0, 8'h81, 0, 8'h01, 2, "rr0_c2");
    addVec(0, 8'h81, 0, 8'h01, 3, "rr0_c3");
    addVec(0, 8'h81, 0, 8'h01, 4, "rr0_c4");
    addVec(0, 8'h81, 0, 8'h00, 0, "rr0_turn");
    addVec(0, 8'h81, 7, 8'h80, 1, "rr7_c1");
    addVec(0, 8'h81, 7, 8'h80, 2, "rr7_c2");
    addVec(0, 8'h81, 7, 8'h80, 3, "rr7_c3");
    addVec(0, 8'h81, 7, 8'h80, 4, "rr7_c4");
    addVec(0, 8'h81, 7, 8'h00, 0, "rr7_turn");
    addVec(0, 8'h81, 0, 8'h01, 1, "rr0b_c1");
    addVec(0, 8'h81, 0, 8'h01, 2, "rr0b_c2");
    addVec(1, 8'h00, 0, 8'h00, 0, "rst_before_early");
    // Early release by 5; next search starts at 6.
    addVec(0, 8'h20, 5, 8'h20, 1, "early_c1");
    addVec(0, 8'h00, 5, 8'h00, 0, "early_drop");
    addVec(0, 8'h41, 6, 8'h40, 1, "early_next6");
    // Reset in the middle of a grant to 6; pointer returns to 0.
    addVec(0, 8'h41, 6, 8'h40, 2, "midrst_c2");
    addVec(1, 8'h41, 0, 8'h00, 0, "midrst_rst");
    addVec(0, 8'h41, 0, 8'h01, 1, "midrst_grant0");
    addVec(0, 8'h00, 0, 8'h00, 0, "midrst_drop");

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].req, 8'h00);
      checkOutput(vecs[i].name, sl, gnt, busy, cnt, vecs[i].sl, vecs[i].gnt, vecs[i].cnt);
    end

    // Unlimited burst: owner 1 holds while 0 also requests. The counter
    // saturates at 15, and 0 is granted only after 1 lets go.
    applyStimulus(1'b0, 8'h00, 8'h02);
    checkOutput("unl_first", sl_u, gnt_u, busy_u, cnt_u, 3'd1, 8'h02, 4'd1);
    for (int k = 0; k < 20; k++) begin
      int e;
      e = (k + 2 > 15) ? 15 : k + 2;
      applyStimulus(1'b0, 8'h00, 8'h03);
      checkOutput($sformatf("unl_hold%0d", k), sl_u, gnt_u, busy_u, cnt_u, 3'd1, 8'h02, 4'(e));
    end
    applyStimulus(1'b0, 8'h00, 8'h01);
    checkOutput("unl_release", sl_u, gnt_u, busy_u, cnt_u, 3'd1, 8'h00, 4'd0);
    applyStimulus(1'b0, 8'h00, 8'h01);
    checkOutput("unl_grant0", sl_u, gnt_u, busy_u, cnt_u, 3'd0, 8'h01, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
